// File: rtl/stack_spill_ctrl_pkg.sv
// Shared definitions for the stack spill/fill sequencer.
package stack_spill_ctrl_pkg;

  // Sequencer states: idle (core-facing), spilling the bottom entry, filling below the bottom.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSpill = 2'd1,
    StFill  = 2'd2
  } state_e;

endpackage

// File: rtl/stack_spill_ctrl.sv
// Sequencer for one on-chip register stack: unlimited-depth push/pop towards the core,
// spilling the bottom entry to memory on overflow and filling it back when the ring runs dry.
module stack_spill_ctrl
  import stack_spill_ctrl_pkg::*;
#(
  parameter int unsigned Dep   = 2,
  parameter int unsigned L     = 16,
  parameter int unsigned Aw    = 16,
  parameter int unsigned Base  = 0,
  parameter int unsigned Msize = 256
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           push_i,
  input  logic           pop_i,
  input  logic [L-1:0]   din_i,
  output logic           ack_o,
  output logic           oflow_o,
  output logic           uflow_o,
  output logic [Dep:0]   cnt_o,
  output logic [Dep-1:0] sp_o,
  output logic [Dep-1:0] spdec_o,
  output logic           spush_o,
  output logic [L-1:0]   sin_o,
  input  logic [L-1:0]   sout_i,
  output logic           mem_req_o,
  output logic           mem_we_o,
  output logic [Aw-1:0]  mem_addr_o,
  output logic [L-1:0]   mem_wdata_o,
  input  logic [L-1:0]   mem_rdata_i,
  input  logic           mem_ack_i
);

  localparam logic [Dep:0]   NEnt   = (Dep+1)'(2 ** Dep);
  localparam logic [Dep:0]   OneCnt = (Dep+1)'(1);
  localparam logic [Dep-1:0] OneIdx = Dep'(1);
  localparam logic [Aw:0]    OneM   = (Aw+1)'(1);
  localparam logic [Aw:0]    BaseW  = (Aw+1)'(Base);
  localparam logic [Aw:0]    MsizeW = (Aw+1)'(Msize);

  state_e         state_q, state_d;
  logic [Dep-1:0] t_q, t_d;
  logic [Dep:0]   c_q, c_d;
  // One extra bit so m can reach Msize even when Msize == 2^Aw - Base.
  logic [Aw:0]    m_q, m_d;

  logic [Dep-1:0] b_idx;
  logic [Dep-1:0] f_idx;
  logic [Aw:0]    spill_addr;
  logic [Aw:0]    fill_addr;

  // Ring positions of the bottom entry and of the free slot just below it.
  always_comb begin
    b_idx      = t_q + c_q[Dep-1:0] - OneIdx;
    f_idx      = t_q + c_q[Dep-1:0];
    spill_addr = BaseW + m_q;
    fill_addr  = BaseW + m_q - OneM;
  end

  assign mem_wdata_o = sout_i;
  assign cnt_o       = c_q;

  // Next-state and output decode for the three-state sequencer.
  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    c_d        = c_q;
    m_d        = m_q;
    ack_o      = 1'b0;
    oflow_o    = 1'b0;
    uflow_o    = 1'b0;
    spush_o    = 1'b0;
    spdec_o    = t_q;
    sin_o      = din_i;
    sp_o       = t_q;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    unique case (state_q)
      StIdle: begin
        if (push_i) begin
          if (pop_i && (c_q != '0)) begin
            // Replace top in place.
            ack_o   = 1'b1;
            spush_o = 1'b1;
            spdec_o = t_q;
          end else if (c_q != NEnt) begin
            ack_o   = 1'b1;
            spush_o = 1'b1;
            spdec_o = t_q - OneIdx;
            t_d     = t_q - OneIdx;
            c_d     = c_q + OneCnt;
          end else if (m_q != MsizeW) begin
            // Core keeps push asserted; it is accepted once the bottom is spilled.
            state_d = StSpill;
          end else begin
            oflow_o = 1'b1;
          end
        end else if (pop_i) begin
          if (c_q != '0) begin
            ack_o = 1'b1;
            t_d   = t_q + OneIdx;
            c_d   = c_q - OneCnt;
            if ((c_q == OneCnt) && (m_q != '0)) begin
              state_d = StFill;
            end
          end else if (m_q != '0) begin
            state_d = StFill;
          end else begin
            ack_o   = 1'b1;
            uflow_o = 1'b1;
          end
        end
      end
      StSpill: begin
        sp_o       = b_idx;
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = spill_addr[Aw-1:0];
        if (mem_ack_i) begin
          m_d     = m_q + OneM;
          c_d     = c_q - OneCnt;
          state_d = StIdle;
        end
      end
      StFill: begin
        mem_req_o  = 1'b1;
        mem_addr_o = fill_addr[Aw-1:0];
        if (mem_ack_i) begin
          spush_o = 1'b1;
          spdec_o = f_idx;
          sin_o   = mem_rdata_i;
          m_d     = m_q - OneM;
          c_d     = c_q + OneCnt;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset abandons any transfer in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      t_q     <= '0;
      c_q     <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      c_q     <= c_d;
      m_q     <= m_d;
    end
  end

endmodule

// File: tb/tb_stack_spill_ctrl.sv
// Scoreboard bench for stack_spill_ctrl with an unbounded-stack reference model.
module tb_stack_spill_ctrl;
  localparam int Dep = 2, N = 4, L = 16, Aw = 16, Base = 16, Msize = 3;

  logic clk = 1'b0;
  logic rst;
  logic push_i, pop_i, spush_o, ack_o, oflow_o, uflow_o;
  logic [L-1:0] din_i, sin_o, sout_i, mem_wdata_o, mem_rdata_i;
  logic [Dep:0] cnt_o;
  logic [Dep-1:0] sp_o, spdec_o;
  logic mem_req_o, mem_we_o, mem_ack_i;
  logic [Aw-1:0] mem_addr_o;

  always #5 clk = ~clk;

  stack_spill_ctrl #(.Dep(Dep), .L(L), .Aw(Aw), .Base(Base), .Msize(Msize)) dut (
    .clk_i(clk), .rst_i(rst), .push_i(push_i), .pop_i(pop_i), .din_i(din_i),
    .ack_o(ack_o), .oflow_o(oflow_o), .uflow_o(uflow_o), .cnt_o(cnt_o), .sp_o(sp_o),
    .spdec_o(spdec_o), .spush_o(spush_o), .sin_o(sin_o), .sout_i(sout_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  // On-chip register stack the parent would provide.
  logic [L-1:0] stk_arr [N];
  always @(posedge clk) if (spush_o) stk_arr[spdec_o] <= sin_o;
  assign sout_i = stk_arr[sp_o];

  int n_pass = 0, n_tot = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: logical stack contents plus on-chip / spilled split.
  typedef struct {
    logic ack, oflow, uflow, has_val;
    logic [L-1:0] val;
    int cnt_after;
  } exp_t;
  exp_t exp_q[$];
  logic [L-1:0] mdl[$];
  int c_m, m_m;

  task automatic model_reset();
    mdl.delete();
    exp_q.delete();
    c_m = 0;
    m_m = 0;
  endtask

  task automatic model_issue(input logic p, input logic q, input logic [L-1:0] d);
    exp_t e;
    e.ack = 0; e.oflow = 0; e.uflow = 0; e.has_val = 0; e.val = '0; e.cnt_after = c_m;
    if (p && q && c_m >= 1) begin
      e.ack = 1; mdl[0] = d;
    end else if (p) begin
      if (c_m < N) begin
        e.ack = 1; mdl.push_front(d); c_m++; e.cnt_after = c_m;
      end else if (m_m < Msize) begin
        e.ack = 1; mdl.push_front(d); m_m++; e.cnt_after = N;
      end else begin
        e.oflow = 1; e.cnt_after = N;
      end
    end else if (q) begin
      e.ack = 1;
      if (mdl.size() == 0) begin
        e.uflow = 1; e.cnt_after = 0;
      end else begin
        e.has_val = 1; e.val = mdl.pop_front(); c_m--; e.cnt_after = c_m;
        // Ring ran dry with entries spilled: one entry comes back before the next request.
        if (c_m == 0 && m_m > 0) begin c_m = 1; m_m--; end
      end
    end
    exp_q.push_back(e);
  endtask

  // Memory with random latency; spurious acks while idle must be ignored.
  logic [L-1:0] mem [int];
  logic mem_stall = 1'b0;
  initial begin
    int lat;
    lat = 0;
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      mem_ack_i = 1'b0;
      if (!rst && !mem_stall) begin
        if (mem_req_o) begin
          if (lat == 0) begin
            check("mem_addr_range",
                  32'((int'(mem_addr_o) >= Base) && (int'(mem_addr_o) < Base + Msize)), 32'd1);
            if (mem_we_o) mem[int'(mem_addr_o)] = mem_wdata_o;
            else mem_rdata_i = mem.exists(int'(mem_addr_o)) ? mem[int'(mem_addr_o)] : 16'hdead;
            mem_ack_i = 1'b1;
            lat = $urandom_range(0, 2);
          end else lat--;
        end else begin
          mem_ack_i = ($urandom_range(0, 7) == 0);
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes a request.
  initial begin
    exp_t e;
    bit cnt_pend;
    int cnt_exp;
    cnt_pend = 0;
    cnt_exp = 0;
    forever begin
      @(negedge clk);
      if (rst) cnt_pend = 0;
      else begin
        if (cnt_pend) begin
          check("cnt_after", 32'(cnt_o), 32'(cnt_exp));
          cnt_pend = 0;
        end
        if (ack_o || oflow_o || uflow_o) begin
          if (exp_q.size() == 0) begin
            n_tot++;
            $display("FAIL unexpected_response: ack=%0b oflow=%0b uflow=%0b, none expected",
                     ack_o, oflow_o, uflow_o);
          end else begin
            e = exp_q.pop_front();
            check("ack", 32'(ack_o), 32'(e.ack));
            check("oflow", 32'(oflow_o), 32'(e.oflow));
            check("uflow", 32'(uflow_o), 32'(e.uflow));
            if (e.has_val) check("pop_data", 32'(sout_i), 32'(e.val));
            cnt_exp = e.cnt_after;
            cnt_pend = 1;
          end
        end
      end
    end
  end

  // Issue one request and hold it until the DUT acks or refuses it.
  task automatic issue(input logic p, input logic q, input logic [L-1:0] d);
    bit done;
    done = 0;
    model_issue(p, q, d);
    push_i = p; pop_i = q; din_i = d;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      done = ack_o | oflow_o;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_tot++;
      $display("FAIL request_timeout: push=%0b pop=%0b not completed in 40 cycles", p, q);
    end
    push_i = 0; pop_i = 0;
  endtask

  initial begin
    rst = 1'b1; push_i = 0; pop_i = 0; din_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack_o), 0);
    check("rst_mem_req", 32'(mem_req_o), 0);
    check("rst_mem_we", 32'(mem_we_o), 0);
    check("rst_cnt", 32'(cnt_o), 0);
    check("rst_sp", 32'(sp_o), 0);
    check("rst_spdec", 32'(spdec_o), 0);
    check("rst_spush", 32'(spush_o), 0);
    check("rst_flags", 32'({oflow_o, uflow_o}), 0);
    rst = 1'b0;

    issue(0, 1, '0);                              // pop on empty: uflow
    for (int i = 1; i <= 4; i++) issue(1, 0, 16'(i));
    for (int i = 0; i < 4; i++) issue(0, 1, '0);  // 4,3,2,1
    for (int i = 1; i <= 5; i++) issue(1, 0, 16'(i));
    check("spill_slot0", 32'(mem[Base]), 32'd1);
    for (int i = 0; i < 5; i++) issue(0, 1, '0);  // 5,4,3,2 then refill, 1
    for (int i = 1; i <= 8; i++) issue(1, 0, 16'(i)); // 8th overflows
    while (mdl.size() > 0) issue(0, 1, '0);
    issue(0, 1, '0);
    issue(1, 0, 16'd7);
    issue(1, 1, 16'd9);                           // replace top
    issue(0, 1, '0);
    issue(1, 1, 16'd3);                           // empty: behaves as push

    for (int i = 0; i < 400; i++) begin
      int r, bias;
      bias = ((i / 40) % 2 == 0) ? 65 : 35;
      r = $urandom_range(0, 99);
      if (r < 10) issue(1, 1, 16'($urandom));
      else if (r < 10 + bias * 9 / 10) issue(1, 0, 16'($urandom));
      else issue(0, 1, '0);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end

    // Reset while a fill is outstanding.
    while (mdl.size() > 0) issue(0, 1, '0);
    for (int i = 1; i <= 5; i++) issue(1, 0, 16'(i + 40));
    mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) issue(0, 1, '0);
    @(negedge clk);
    check("fill_req", 32'(mem_req_o), 1);
    check("fill_we", 32'(mem_we_o), 0);
    check("fill_addr", 32'(mem_addr_o), 32'(Base));
    #2 rst = 1'b1;
    #1;
    check("rst_fill_req", 32'(mem_req_o), 0);
    check("rst_fill_cnt", 32'(cnt_o), 0);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_stall = 1'b0;
    model_reset();
    issue(0, 1, '0);
    issue(1, 0, 16'h1234);
    issue(0, 1, '0);
    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
